// File: rtl/sensor_event_fsm_pkg.sv
// sensor_event_fsm_pkg: shared press-classifier states, default timing constants and width helper.
package sensor_event_fsm_pkg;
  typedef enum logic [1:0] {IDLE, PRESS, HOLD, LOCKOUT} state_e;
  localparam int DEF_LONG_CYCLES = 20;
  localparam int DEF_REPEAT_CYCLES = 8;
  localparam int DEF_LOCKOUT_CYCLES = 4;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/sensor_evt_timer.sv
// sensor_evt_timer: loadable up-counter with clear and terminal-count compare.
module sensor_evt_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : load ? load_val : inc ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign tc = cnt_q == term;
endmodule

// File: rtl/sensor_event_fsm.sv
// sensor_event_fsm: debounced level to short/long/repeat press events; SENSOR_EVT_REPEAT_EN enables auto-repeat.
module sensor_event_fsm
  import sensor_event_fsm_pkg::*;
#(
  parameter int LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_level,
  output logic       evt_short,
  output logic       evt_long,
  output logic       evt_repeat,
  output logic       hold_active,
  output logic [7:0] press_count
);
  localparam int CW = $clog2(max3(LONG_CYCLES, REPEAT_CYCLES, LOCKOUT_CYCLES) + 1);
  state_e state_q, state_d;
  logic evt_short_q, evt_short_d, evt_long_q, evt_long_d, evt_repeat_q, evt_repeat_d;
  logic hold_active_q, hold_active_d;
  logic [7:0] press_count_q, press_count_d;
  logic clr, inc, tc;
  logic [CW-1:0] term;
  sensor_evt_timer #(.W(CW)) u_timer (
    .clk(clk), .reset(reset), .clr(clr), .load(1'b0), .load_val('0),
    .inc(inc), .term(term), .tc(tc)
  );
  always_comb term = state_q == PRESS ? CW'(LONG_CYCLES - 1) :
                     state_q == HOLD  ? CW'(REPEAT_CYCLES - 1) : CW'(LOCKOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    press_count_d = press_count_q;
    evt_short_d = 1'b0;
    evt_long_d = 1'b0;
    evt_repeat_d = 1'b0;
    clr = 1'b0;
    inc = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = sensor_level ? PRESS : IDLE;
        clr = sensor_level;
      end
      PRESS: begin
        clr = !sensor_level || tc;
        inc = !clr;
        evt_short_d = !sensor_level;
        evt_long_d = sensor_level && tc;
        state_d = !sensor_level ? LOCKOUT : tc ? HOLD : PRESS;
        press_count_d = press_count_q + {7'd0, clr};
      end
      HOLD: begin
        state_d = sensor_level ? HOLD : LOCKOUT;
`ifdef SENSOR_EVT_REPEAT_EN
        evt_repeat_d = sensor_level && tc;
        clr = !sensor_level || tc;
        inc = !clr;
`else
        clr = !sensor_level;
`endif
      end
      default: begin
        state_d = tc ? IDLE : LOCKOUT;
        clr = tc;
        inc = !tc;
      end
    endcase
    hold_active_d = state_d == PRESS || state_d == HOLD;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      evt_short_q <= 1'b0;
      evt_long_q <= 1'b0;
      evt_repeat_q <= 1'b0;
      hold_active_q <= 1'b0;
      press_count_q <= '0;
    end else begin
      state_q <= state_d;
      evt_short_q <= evt_short_d;
      evt_long_q <= evt_long_d;
      evt_repeat_q <= evt_repeat_d;
      hold_active_q <= hold_active_d;
      press_count_q <= press_count_d;
    end
  end
  assign evt_short = evt_short_q;
  assign evt_long = evt_long_q;
  assign evt_repeat = evt_repeat_q;
  assign hold_active = hold_active_q;
  assign press_count = press_count_q;
endmodule

// File: tb/tb_sensor_event_fsm.sv
// tb_sensor_event_fsm: directed presses with a scoreboard of expected event pulses.
module tb_sensor_event_fsm;
  import sensor_event_fsm_pkg::*;
  localparam int LONG = 20;
  localparam int REP = 8;
  localparam int LO = 4;
  typedef struct {int kind; int edge_n; int cnt;} exp_t;
  logic clk = 1'b0, reset = 1'b1, sensor_level = 1'b0;
  logic evt_short, evt_long, evt_repeat, hold_active;
  logic [7:0] press_count;
  logic [7:0] exp_count = '0;
  int cyc = 0, n_chk = 0, n_fail = 0, kind;
  exp_t exp_q[$];
  exp_t e;
  sensor_event_fsm #(.LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .LOCKOUT_CYCLES(LO)) dut (
    .clk(clk), .reset(reset), .sensor_level(sensor_level), .evt_short(evt_short),
    .evt_long(evt_long), .evt_repeat(evt_repeat), .hold_active(hold_active),
    .press_count(press_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic push(input int k, input int ed);
    exp_t x;
    x.kind = k;
    x.edge_n = ed;
    x.cnt = int'(exp_count);
    exp_q.push_back(x);
  endtask
  // Level high for hi edges starting at N, then low long enough to leave lockout.
  task automatic press(input int hi);
    int n;
    @(negedge clk);
    n = cyc + 1;
    exp_count++;
    if (hi <= LONG) push(0, n + hi);
    else begin
      push(1, n + LONG);
`ifdef SENSOR_EVT_REPEAT_EN
      for (int j = 1; LONG + j * REP < hi; j++) push(2, n + LONG + j * REP);
`endif
    end
    sensor_level = 1'b1;
    repeat (hi - 1) @(negedge clk);
    @(negedge clk);
    sensor_level = 1'b0;
    repeat (LO) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (evt_short || evt_long || evt_repeat) begin
      chk("evt_exclusive", int'(evt_short) + int'(evt_long) + int'(evt_repeat), 1);
      kind = evt_long ? 1 : evt_repeat ? 2 : 0;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: kind %0d at edge %0d, none expected", kind, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("evt_kind", kind, e.kind);
        chk("evt_edge", cyc, e.edge_n);
        chk("evt_count", int'(press_count), e.cnt);
      end
    end
  end
  initial begin
    int r;
    repeat (2) @(negedge clk);
    chk("rst_short", int'(evt_short), 0);
    chk("rst_long", int'(evt_long), 0);
    chk("rst_repeat", int'(evt_repeat), 0);
    chk("rst_hold", int'(hold_active), 0);
    chk("rst_count", int'(press_count), 0);
    reset = 1'b0;
    press(5);
    chk("short5_count", int'(press_count), 1);
    chk("short5_hold", int'(hold_active), 0);
    press(20);
    press(21);
    press(40);
    chk("long40_count", int'(press_count), 4);
    @(negedge clk);
    r = cyc + 4;
    exp_count++;
    push(0, r);
    exp_count++;
    push(0, r + 7);
    sensor_level = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    sensor_level = 1'b0;
    @(negedge clk);
    sensor_level = 1'b1;
    @(negedge clk);
    sensor_level = 1'b0;
    @(negedge clk);
    sensor_level = 1'b1;
    @(negedge clk);
    chk("lock_hold_r3", int'(hold_active), 0);
    @(negedge clk);
    chk("lock_hold_r4", int'(hold_active), 0);
    @(negedge clk);
    chk("lock_hold_r5", int'(hold_active), 1);
    @(negedge clk);
    sensor_level = 1'b0;
    repeat (LO) @(negedge clk);
    @(negedge clk);
    sensor_level = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_hold", int'(hold_active), 0);
    chk("midrst_count", int'(press_count), 0);
    chk("midrst_evts", int'(evt_short) + int'(evt_long) + int'(evt_repeat), 0);
    sensor_level = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_count = '0;
    press(5);
    chk("postrst_count", int'(press_count), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_count = '0;
    for (int i = 0; i < 256; i++) press(1);
    chk("wrap_count", int'(press_count), 0);
    press(1);
    chk("wrap_plus1", int'(press_count), 1);
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
